cust_hp_filter_sched: RTL and testbench

//  Round-robin scheduler that shares one cust HP filter instance between N_REQ sample sources.

---
 rtl/cust_hp_filter_sched.sv | 165 ++++++++++++++++
 tb/tb_cust_hp_filter_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cust_hp_filter_sched.sv
// Round-robin sharing of one HP filter among N_REQ sources, with drained coeff updates.
// Optional SCHED_STATS_EN adds per-requester grant counters read via stat_sel/stat_count.
module cust_hp_filter_sched #(
  parameter int N_REQ        = 4,
  parameter int CHANNELS_PW2 = 7,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [16*N_REQ-1:0]             req_sample,
  input  logic [CHANNELS_PW2*N_REQ-1:0]   req_num,
  output logic [N_REQ-1:0]                req_ack,
  output logic [15:0]                     chan_in_sample,
  output logic [CHANNELS_PW2-1:0]         chan_in_num,
  output logic                            chan_in_valid,
  input  logic                            chan_in_read,
  input  logic                            flt_out_valid,
  input  logic                            flt_out_read,
  input  logic                            cfg_coeff_wr,
  input  logic [15:0]                     cfg_coeff_data,
`ifdef SCHED_STATS_EN
  input  logic [2:0]                      stat_sel,
  output logic [15:0]                     stat_count,
`endif
  output logic [15:0]                     coeff,
  output logic                            coeff_busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] MAXI = 4'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    UPDATE
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           gidx;
  logic                    found;
  logic                    grant;
  logic [3:0]              inflight;
  logic [15:0]             pend;
  logic                    hs;
  logic                    rd;
  logic [15:0]             smp [N_REQ];
  logic [CHANNELS_PW2-1:0] num [N_REQ];

  assign hs = chan_in_valid & chan_in_read;
  assign rd = flt_out_valid & flt_out_read;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      smp[i] = req_sample[16*i +: 16];
      num[i] = req_num[CHANNELS_PW2*i +: CHANNELS_PW2];
    end
  end

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    found = 1'b0;
    gidx  = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ))
        sum = sum - (PW+1)'(N_REQ);
      idx = sum[PW-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (coeff_busy)
          state_d = DRAIN;
        else if (found && inflight < MAXI) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: if (hs) state_d = IDLE;
      DRAIN: if (inflight == 4'd0) state_d = UPDATE;
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ack        <= '0;
      chan_in_sample <= '0;
      chan_in_num    <= '0;
      chan_in_valid  <= 1'b0;
      rr_ptr         <= '0;
      inflight       <= '0;
      pend           <= '0;
      coeff          <= '0;
      coeff_busy     <= 1'b0;
    end else begin
      req_ack <= '0;
      if (grant) begin
        req_ack[gidx]  <= 1'b1;
        chan_in_sample <= smp[gidx];
        chan_in_num    <= num[gidx];
        rr_ptr <= (gidx == PW'(N_REQ-1)) ? '0 : gidx + 1'b1;
      end
      // valid rises one cycle after the grant and drops after the read
      if (state_q == ISSUE)
        chan_in_valid <= !hs;
      else
        chan_in_valid <= 1'b0;
      if (hs && !rd && inflight < MAXI)
        inflight <= inflight + 4'd1;
      else if (rd && !hs && inflight != 4'd0)
        inflight <= inflight - 4'd1;
      if (cfg_coeff_wr) begin
        pend       <= cfg_coeff_data;
        coeff_busy <= 1'b1;
      end else if (state_q == UPDATE) begin
        coeff_busy <= 1'b0;
      end
      if (state_q == UPDATE)
        coeff <= pend;
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] cnt [N_REQ];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      if (grant)
        cnt[gidx] <= cnt[gidx] + 16'd1;
      stat_count <= '0;
      for (int i = 0; i < N_REQ; i++)
        if (stat_sel == 3'(i))
          stat_count <= cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_cust_hp_filter_sched.sv
// Bench for cust_hp_filter_sched: directed scenarios plus random traffic
// checked every cycle against a transaction-level scheduler model.
module tb_cust_hp_filter_sched;
  localparam int N    = 4;
  localparam int CW   = 7;
  localparam int MAXI = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_sample = '0;
  logic [CW*N-1:0] req_num = '0;
  logic [N-1:0]    req_ack;
  logic [15:0]     chan_in_sample;
  logic [CW-1:0]   chan_in_num;
  logic            chan_in_valid;
  logic            chan_in_read = 1'b0;
  logic            flt_out_valid = 1'b0;
  logic            flt_out_read = 1'b0;
  logic            cfg_coeff_wr = 1'b0;
  logic [15:0]     cfg_coeff_data = '0;
  logic [15:0]     coeff;
  logic            coeff_busy;
`ifdef SCHED_STATS_EN
  logic [2:0]      stat_sel = '0;
  logic [15:0]     stat_count;
`endif

  cust_hp_filter_sched #(
    .N_REQ(N), .CHANNELS_PW2(CW), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_sample(req_sample),
    .req_num(req_num), .req_ack(req_ack),
    .chan_in_sample(chan_in_sample), .chan_in_num(chan_in_num),
    .chan_in_valid(chan_in_valid), .chan_in_read(chan_in_read),
    .flt_out_valid(flt_out_valid), .flt_out_read(flt_out_read),
    .cfg_coeff_wr(cfg_coeff_wr), .cfg_coeff_data(cfg_coeff_data),
`ifdef SCHED_STATS_EN
    .stat_sel(stat_sel), .stat_count(stat_count),
`endif
    .coeff(coeff), .coeff_busy(coeff_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model, one step per cycle ----------------
  logic [N-1:0]    pv = '0;
  logic [15:0]     ps [N];
  logic [CW-1:0]   pn [N];
  logic [CW+15:0]  q [$];
  int              m_rr = 0, m_infl = 0, infl_last = 0;
  int              idle = 0, coeff_chg = 0;
  bit              m_busy = 0, busy_last = 0, qe_last = 1;
  logic [15:0]     m_pend = '0, m_coeff = '0, coeff_prev = '0;

  always @(negedge clk) begin
    bit qe;
    int g, e;
    if (coeff !== coeff_prev) coeff_chg++;
    coeff_prev = coeff;
    if (!reset) begin
      q.delete();
      m_rr = 0; m_infl = 0; infl_last = 0; idle = 0;
      m_busy = 0; busy_last = 0; qe_last = 1;
      m_pend = '0; m_coeff = '0;
      chk("rst_ctl", {req_ack, chan_in_valid, coeff_busy}, 0);
      chk("rst_data", {chan_in_sample, coeff}, 0);
      chk("rst_num", chan_in_num, 0);
    end else begin
      qe = (q.size() == 0);
      chk("in_valid", chan_in_valid, !qe);
      if (!qe && chan_in_valid)
        chk("in_data", {chan_in_num, chan_in_sample}, q[0]);
      if (req_ack != '0) begin
        chk("ack_onehot", $onehot(req_ack), 1);
        g = 0;
        for (int i = N-1; i >= 0; i--) if (req_ack[i]) g = i;
        e = -1;
        for (int k = N-1; k >= 0; k--)
          if (pv[(m_rr+k)%N]) e = (m_rr+k)%N;
        chk("grant_idx", g, e);
        chk("grant_legal",
            {infl_last < MAXI, !busy_last, qe_last, qe}, 4'hF);
        q.push_back({pn[g], ps[g]});
        m_rr = (g + 1) % N;
      end
      if (m_busy && !coeff_busy) begin
        chk("upd_legal", {m_infl == 0, qe}, 2'b11);
        chk("upd_coeff", coeff, m_pend);
        m_coeff = m_pend;
        m_busy = 0;
      end else begin
        chk("busy", coeff_busy, m_busy);
        chk("coeff", coeff, m_coeff);
      end
      if (qe && req_ack == '0 && !m_busy && m_infl < MAXI && req_valid != '0)
        idle++;
      else
        idle = 0;
      if (idle > 0) chk("stall", idle <= 3, 1);
      infl_last = m_infl;
      if (!qe && chan_in_read && !(flt_out_valid && flt_out_read))
        m_infl = (m_infl < MAXI) ? m_infl + 1 : MAXI;
      else if (flt_out_valid && flt_out_read && !(!qe && chan_in_read))
        m_infl = (m_infl > 0) ? m_infl - 1 : 0;
      if (!qe && chan_in_read) void'(q.pop_front());
      busy_last = m_busy;
      if (cfg_coeff_wr) begin
        m_busy = 1;
        m_pend = cfg_coeff_data;
      end
      qe_last = qe;
    end
    pv = req_valid;
    for (int i = 0; i < N; i++) begin
      ps[i] = req_sample[16*i +: 16];
      pn[i] = req_num[CW*i +: CW];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0; chan_in_read = 0;
    flt_out_valid = 0; flt_out_read = 0; cfg_coeff_wr = 0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic wait_ack(input int lim, output int g, output int n);
    g = -1;
    n = 0;
    while (g < 0 && n < lim) begin
      tick();
      n++;
      for (int i = N-1; i >= 0; i--) if (req_ack[i]) g = i;
    end
  endtask

  task automatic count_acks(input int cyc, inout int cnt);
    repeat (cyc) begin
      tick();
      if (req_ack != '0) cnt++;
    end
  endtask

  task automatic wait_idle_busy(input int lim);
    int n;
    n = 0;
    while (coeff_busy && n < lim) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, n, cnt, c0;
    logic [N-1:0] clr, seen;
    for (int i = 0; i < N; i++) begin
      req_sample[16*i +: 16] = 16'h1000 + 16'(i);
      req_num[CW*i +: CW]    = 7'(10 + i);
    end

    // 1: outputs quiet in reset, then round-robin with tied read
    req_valid = '1;
    chan_in_read = 1; flt_out_valid = 1; flt_out_read = 1;
    repeat (4) tick();
    chk("t1_rst_outputs", {req_ack, chan_in_valid, coeff_busy, chan_in_sample}, 0);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(12, g, n);
      chk("t1_order", g, k % 4);
      if (k > 0) chk("t1_period", n, 2);
      tick();
      chk("t1_ack_width", req_ack, 0);
    end

    // 2: read held low keeps the issue stable
    do_reset();
    req_valid = 4'b0100;
    req_sample[47:32] = 16'hABCD;
    req_num[20:14] = 7'd5;
    wait_ack(10, g, n);
    chk("t2_grant", g, 2);
    tick();
    repeat (10) begin
      chk("t2_hold", {chan_in_valid, chan_in_num, chan_in_sample},
          {1'b1, 7'd5, 16'hABCD});
      chk("t2_no_regrant", req_ack, 0);
      tick();
    end
    chan_in_read = 1;
    tick();

    // 3: inflight cap
    do_reset();
    req_valid = '1; chan_in_read = 1;
    cnt = 0;
    count_acks(40, cnt);
    chk("t3_cap", cnt, 4);
    flt_out_valid = 1; flt_out_read = 1;
    tick();
    flt_out_valid = 0; flt_out_read = 0;
    count_acks(20, cnt);
    chk("t3_one_more", cnt, 5);

    // 4: coeff change waits for drain
    do_reset();
    req_valid = '1; chan_in_read = 1;
    cnt = 0;
    n = 0;
    while (cnt < 2 && n < 20) begin
      tick();
      n++;
      if (req_ack != '0) cnt++;
    end
    req_valid = '0;
    repeat (4) tick();
    cfg_coeff_wr = 1; cfg_coeff_data = 16'd3991;
    tick();
    cfg_coeff_wr = 0; req_valid = '1;
    cnt = 0;
    count_acks(10, cnt);
    chk("t4_no_grant", cnt, 0);
    chk("t4_busy", coeff_busy, 1);
    chk("t4_coeff_old", coeff, 0);
    repeat (2) begin
      flt_out_valid = 1; flt_out_read = 1;
      tick();
      flt_out_valid = 0; flt_out_read = 0;
      tick();
    end
    wait_idle_busy(10);
    chk("t4_busy_clr", coeff_busy, 0);
    chk("t4_coeff", coeff, 16'd3991);
    wait_ack(10, g, n);
    chk("t4_resume", g >= 0, 1);

    // 5: last write wins, single update
    do_reset();
    req_valid = 4'b0001; chan_in_read = 1;
    wait_ack(10, g, n);
    req_valid = '0;
    repeat (4) tick();
    c0 = coeff_chg;
    cfg_coeff_wr = 1; cfg_coeff_data = 16'd10;
    tick();
    cfg_coeff_wr = 0;
    tick(); tick();
    cfg_coeff_wr = 1; cfg_coeff_data = 16'd3991;
    tick();
    cfg_coeff_wr = 0;
    tick();
    chk("t5_busy", coeff_busy, 1);
    chk("t5_coeff_hold", coeff, 0);
    flt_out_valid = 1; flt_out_read = 1;
    tick();
    flt_out_valid = 0; flt_out_read = 0;
    wait_idle_busy(10);
    chk("t5_coeff", coeff, 16'd3991);
    repeat (3) tick();
    chk("t5_one_update", coeff_chg - c0, 1);

    // 6: reset during issue
    do_reset();
    req_valid = 4'b0010;
    wait_ack(10, g, n);
    chk("t6_grant", g, 1);
    tick();
    chk("t6_issue", chan_in_valid, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", chan_in_valid, 0);
    chk("t6_rst_sample", chan_in_sample, 0);
    tick(); tick();
    reset = 1'b1;
    chan_in_read = 1;
    cnt = 0;
    count_acks(40, cnt);
    chk("t6_infl_clr", cnt, 4);
`ifdef SCHED_STATS_EN
    do_reset();
    req_valid = 4'b0010; chan_in_read = 1;
    flt_out_valid = 1; flt_out_read = 1;
    cnt = 0;
    n = 0;
    while (cnt < 5 && n < 40) begin
      tick();
      n++;
      if (req_ack != '0) cnt++;
    end
    req_valid = '0;
    stat_sel = 3'd1;
    tick(); tick();
    chk("t6_stat1", stat_count, 5);
    stat_sel = 3'd0;
    tick(); tick();
    chk("t6_stat0", stat_count, 0);
`endif

    // random traffic against the model
    do_reset();
    clr = '0;
    repeat (3000) begin
      tick();
      seen = req_ack;
      for (int i = 0; i < N; i++) begin
        if (clr[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) == 0 || clr[i]) begin
            req_valid[i] = $urandom_range(0, 1) == 1;
            req_sample[16*i +: 16] = 16'($urandom);
            req_num[CW*i +: CW]    = 7'($urandom);
          end
        end
      end
      clr = seen;
      chan_in_read  = $urandom_range(0, 1) == 1;
      flt_out_valid = $urandom_range(0, 2) != 0;
      flt_out_read  = $urandom_range(0, 1) == 1;
      if (!m_busy && $urandom_range(0, 99) == 0) begin
        cfg_coeff_wr   = 1;
        cfg_coeff_data = 16'($urandom);
      end else begin
        cfg_coeff_wr = 0;
      end
    end
    req_valid = '0; cfg_coeff_wr = 0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
